// File: rtl/sta_seq_pkg.sv
// rtl/sta_seq_pkg.sv - shared types and AXI constants for the systolic-array job sequencer
//   state_e : sequencer FSM states
//   phase_e : which input region the write path is filling
//   SIZE_4B, BURST_INCR, RESP_OKAY, CACHE_DEFAULT : fixed AXI field values
package sta_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_AW,
    S_WR_W,
    S_WR_B,
    S_ST_AW,
    S_ST_W,
    S_ST_B,
    S_PL_AR,
    S_PL_R,
    S_RD_AR,
    S_RD_R,
    S_FIN
  } state_e;

  typedef enum logic {
    PH_WGT,
    PH_IN
  } phase_e;

  localparam logic [2:0] SIZE_4B       = 3'b010;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  // Width of a counter that must hold the value n itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sta_seq_burst_cnt.sv
// rtl/sta_seq_burst_cnt.sv - beat-within-burst and word-within-phase counter
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : restart both counts at zero (new phase)
//   advance      : one data beat accepted this cycle
//   phase_words  : number of words in the current phase
//   beat_last    : current beat is beat BURST_LEN-1 of its burst
//   word_last    : current beat is the last word of the phase
//   phase_done   : every word of the phase has been transferred
module sta_seq_burst_cnt #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned WORD_W    = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [WORD_W-1:0] phase_words,
  output logic              beat_last,
  output logic              word_last,
  output logic              phase_done
);

  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WORD_W-1:0] word_q, word_d;

  assign beat_last  = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign word_last  = (word_q == (phase_words - WORD_W'(1)));
  assign phase_done = (word_q == phase_words);

  always_comb begin
    beat_d = beat_q;
    word_d = word_q;
    if (clear) begin
      beat_d = '0;
      word_d = '0;
    end else if (advance) begin
      // Beat count wraps at the burst boundary so every burst starts at 0.
      beat_d = beat_last ? '0 : beat_q + BEAT_W'(1);
      word_d = word_q + WORD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      word_q <= '0;
    end else begin
      beat_q <= beat_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/sta_job_sequencer.sv
// rtl/sta_job_sequencer.sv - AXI4 master running one job on the 32x32 systolic array
//   clk, rst            : clock, asynchronous active-low reset
//   job_start           : start pulse, accepted only when idle
//   busy/job_done/job_err : job status; job_err qualifies job_done
//   s_data_*            : input words (N_WGT weights then N_IN activations)
//   m_data_*            : result words, m_data_last on the final one
//   m_axi_*             : AXI4 master port to the array slave
//   perf_cycles         : busy-cycle counter, present only with STA_SEQ_PERF_EN
module sta_job_sequencer
  import sta_seq_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 20,
  parameter int unsigned            STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned            ID_WIDTH   = 8,
  parameter int unsigned            N_WGT      = 1024,
  parameter int unsigned            N_IN       = 32,
  parameter int unsigned            N_OUT      = 32,
  parameter int unsigned            BURST_LEN  = 16,
  parameter logic [ADDR_WIDTH-1:0]  WGT_BASE   = 20'h00000,
  parameter logic [ADDR_WIDTH-1:0]  IN_BASE    = 20'h01000,
  parameter logic [ADDR_WIDTH-1:0]  OUT_BASE   = 20'h02000,
  parameter logic [ADDR_WIDTH-1:0]  CTRL_ADDR  = 20'h03000,
  parameter logic [ADDR_WIDTH-1:0]  STAT_ADDR  = 20'h03004,
  parameter int unsigned            POLL_MAX   = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_start,
  output logic                  busy,
  output logic                  job_done,
  output logic                  job_err,
  input  logic                  s_data_valid,
  output logic                  s_data_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_data_valid,
  input  logic                  m_data_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_data_last,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
`ifdef STA_SEQ_PERF_EN
  output logic [31:0]           perf_cycles,
`endif
  output logic                  m_axi_rready
);

  localparam int unsigned N_MAX_A = (N_WGT > N_IN) ? N_WGT : N_IN;
  localparam int unsigned N_MAX   = (N_MAX_A > N_OUT) ? N_MAX_A : N_OUT;
  localparam int unsigned WORD_W  = cnt_width(N_MAX);
  localparam int unsigned POLL_W  = cnt_width(POLL_MAX);
  localparam logic [7:0]  LEN_BURST   = 8'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 4);

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic [POLL_W-1:0]     poll_q, poll_d;

  logic wr_clear, rd_clear;
  logic wr_beat_last, wr_phase_done, wr_word_last_unused;
  logic rd_beat_last, rd_word_last, rd_phase_done_unused;
  logic rd_drain, resp_r_bad, resp_b_bad;
  logic unused_inputs;

  // Response IDs are always 0 and burst ends come from our own beat count.
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast};

  assign resp_b_bad = (m_axi_bresp != RESP_OKAY);
  assign resp_r_bad = (m_axi_rresp != RESP_OKAY);
  // Once a read error is seen the rest of the burst is swallowed, not forwarded.
  assign rd_drain   = err_q || resp_r_bad;

  assign m_axi_awid    = '0;
  assign m_axi_awsize  = SIZE_4B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_DEFAULT;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wstrb   = '1;
  assign m_axi_arid    = '0;
  assign m_axi_arsize  = SIZE_4B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = CACHE_DEFAULT;
  assign m_axi_arprot  = 3'b000;

  assign busy     = (state_q != S_IDLE);
  assign job_done = (state_q == S_FIN);
  assign job_err  = (state_q == S_FIN) && err_q;

  sta_seq_burst_cnt #(
    .BURST_LEN (BURST_LEN),
    .WORD_W    (WORD_W)
  ) u_wr_cnt (
    .clk         (clk),
    .rst_n       (rst),
    .clear       (wr_clear),
    .advance     ((state_q == S_WR_W) && s_data_valid && m_axi_wready),
    .phase_words ((phase_q == PH_WGT) ? WORD_W'(N_WGT) : WORD_W'(N_IN)),
    .beat_last   (wr_beat_last),
    .word_last   (wr_word_last_unused),
    .phase_done  (wr_phase_done)
  );

  sta_seq_burst_cnt #(
    .BURST_LEN (BURST_LEN),
    .WORD_W    (WORD_W)
  ) u_rd_cnt (
    .clk         (clk),
    .rst_n       (rst),
    .clear       (rd_clear),
    .advance     ((state_q == S_RD_R) && m_axi_rvalid && m_axi_rready),
    .phase_words (WORD_W'(N_OUT)),
    .beat_last   (rd_beat_last),
    .word_last   (rd_word_last),
    .phase_done  (rd_phase_done_unused)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_WGT;
      addr_q  <= '0;
      err_q   <= 1'b0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      poll_q  <= poll_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    addr_d   = addr_q;
    err_d    = err_q;
    poll_d   = poll_q;
    wr_clear = 1'b0;
    rd_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          state_d  = S_WR_AW;
          phase_d  = PH_WGT;
          addr_d   = WGT_BASE;
          err_d    = 1'b0;
          poll_d   = '0;
          wr_clear = 1'b1;
        end
      end
      S_WR_AW: if (m_axi_awready) state_d = S_WR_W;
      S_WR_W: begin
        if (s_data_valid && m_axi_wready && wr_beat_last) state_d = S_WR_B;
      end
      S_WR_B: begin
        if (m_axi_bvalid) begin
          if (resp_b_bad) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (wr_phase_done) begin
            if (phase_q == PH_WGT) begin
              phase_d  = PH_IN;
              addr_d   = IN_BASE;
              wr_clear = 1'b1;
              state_d  = S_WR_AW;
            end else begin
              state_d = S_ST_AW;
            end
          end else begin
            addr_d  = addr_q + BURST_BYTES;
            state_d = S_WR_AW;
          end
        end
      end
      S_ST_AW: if (m_axi_awready) state_d = S_ST_W;
      S_ST_W:  if (m_axi_wready) state_d = S_ST_B;
      S_ST_B: begin
        if (m_axi_bvalid) begin
          poll_d = '0;
          if (resp_b_bad) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_PL_AR;
          end
        end
      end
      S_PL_AR: if (m_axi_arready) state_d = S_PL_R;
      S_PL_R: begin
        if (m_axi_rvalid) begin
          if (resp_r_bad) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (m_axi_rdata[0]) begin
            addr_d   = OUT_BASE;
            rd_clear = 1'b1;
            state_d  = S_RD_AR;
          end else if (poll_q == POLL_W'(POLL_MAX - 1)) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            poll_d  = poll_q + POLL_W'(1);
            state_d = S_PL_AR;
          end
        end
      end
      S_RD_AR: if (m_axi_arready) state_d = S_RD_R;
      S_RD_R: begin
        if (m_axi_rvalid && m_axi_rready) begin
          if (resp_r_bad) err_d = 1'b1;
          if (rd_beat_last) begin
            if (rd_drain || rd_word_last) begin
              state_d = S_FIN;
            end else begin
              addr_d  = addr_q + BURST_BYTES;
              state_d = S_RD_AR;
            end
          end
        end
      end
      S_FIN: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: data channels are pure pass-throughs while their state is active.
  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_awaddr  = addr_q;
    m_axi_awlen   = LEN_BURST;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = s_data;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = addr_q;
    m_axi_arlen   = LEN_BURST;
    m_axi_rready  = 1'b0;
    s_data_ready  = 1'b0;
    m_data_valid  = 1'b0;
    m_data        = m_axi_rdata;
    m_data_last   = 1'b0;
    case (state_q)
      S_WR_AW: m_axi_awvalid = 1'b1;
      S_WR_W: begin
        m_axi_wvalid = s_data_valid;
        s_data_ready = m_axi_wready;
        m_axi_wlast  = wr_beat_last;
      end
      S_WR_B, S_ST_B: m_axi_bready = 1'b1;
      S_ST_AW: begin
        m_axi_awvalid = 1'b1;
        m_axi_awaddr  = CTRL_ADDR;
        m_axi_awlen   = 8'd0;
      end
      S_ST_W: begin
        m_axi_wvalid = 1'b1;
        m_axi_wdata  = DATA_WIDTH'(1);
        m_axi_wlast  = 1'b1;
      end
      S_PL_AR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = STAT_ADDR;
        m_axi_arlen   = 8'd0;
      end
      S_PL_R: m_axi_rready = 1'b1;
      S_RD_AR: m_axi_arvalid = 1'b1;
      S_RD_R: begin
        m_axi_rready = rd_drain ? 1'b1 : m_data_ready;
        m_data_valid = m_axi_rvalid && !rd_drain;
        m_data_last  = rd_word_last;
      end
      default: ;
    endcase
  end

`ifdef STA_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && job_start) begin
      perf_d = '0;
    end else if ((state_q != S_IDLE) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule
